// File: rtl/sha3_pkg.sv
// Shared SHA3 types and constants: Keccak state layout, chunking geometry and the
// lane-order flattening used by both the chunk loader and the unloader.
package sha3_pkg;

  localparam int unsigned LANE_W  = 64;
  localparam int unsigned CHUNK_W = 200;
  localparam int unsigned NCHUNK  = 8;
  localparam int unsigned STATE_W = LANE_W * 25;
  localparam logic [2:0]  LAST_IDX = 3'(NCHUNK - 1);

  typedef logic [4:0][4:0][63:0] state_t;

  typedef enum logic [0:0] {IDLE, SEND} fsm_e;

  // Lane (x,y) lands at lane slot 5*y+x, so lane 0 sits in the low 64 bits.
  function automatic logic [STATE_W-1:0] flatten(input state_t a);
    logic [STATE_W-1:0] s;
    s = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        s[LANE_W*(5*y+x) +: LANE_W] = a[x][y];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/sha3_state_unload.sv
// Serialises a full Keccak state into eight 200-bit chunks (chunk 0 first), with a
// one-deep pending buffer so consecutive states stream without a bubble.
module sha3_state_unload
  import sha3_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               pushin,
  input  state_t             A,
  output logic               stopout,
  output logic               pushout,
  output logic [CHUNK_W-1:0] dout,
  output logic [2:0]         dix,
  input  logic               stopin
);

  fsm_e               st;
  logic [STATE_W-1:0] act;
  logic [STATE_W-1:0] pend;
  logic               pend_v;
  logic [2:0]         cnt;

  logic in_xfer;
  logic beat;

  assign in_xfer = pushin && !pend_v;
  assign beat    = (st == SEND) && !stopin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      act    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_xfer) begin
            act <= flatten(A);
            cnt <= '0;
            st  <= SEND;
          end
        end
        SEND: begin
          if (beat && cnt == LAST_IDX) begin
            // Pending state wins over a fresh input; pend_v blocks in_xfer then anyway.
            if (pend_v) begin
              act    <= pend;
              pend_v <= 1'b0;
              cnt    <= '0;
            end else if (in_xfer) begin
              act <= flatten(A);
              cnt <= '0;
            end else begin
              st <= IDLE;
            end
          end else begin
            if (beat) begin
              act <= act >> CHUNK_W;
              cnt <= cnt + 3'd1;
            end
            if (in_xfer) begin
              pend   <= flatten(A);
              pend_v <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign stopout = pend_v;
  assign pushout = (st == SEND);
  assign dout    = act[CHUNK_W-1:0];
  assign dix     = cnt;

endmodule
